// File: rtl/pending_enc_pkg.sv
// Shared constants, state encoding and helpers for the pending-event encoder.
package pending_enc_pkg;

  localparam int NO_OF_INS = 32;
  localparam int SELECT    = $clog2(NO_OF_INS);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Index zero-extends into the vector, so every index maps to a real line.
  function automatic logic [NO_OF_INS-1:0] onehot(input logic [SELECT-1:0] idx);
    logic [NO_OF_INS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/prio_enc32_5.sv
// Combinational lowest-set-bit encoder: NO_OF_INS request vector to SELECT index plus any flag.
module prio_enc32_5
  import pending_enc_pkg::*;
(
  input  logic [NO_OF_INS-1:0] vec,
  output logic [SELECT-1:0]    idx,
  output logic                 any
);

  logic [NO_OF_INS-1:0] first;

  // first[gi] is set only for the lowest set bit, so the OR-merge below is exact.
  genvar gi;
  generate
    for (gi = 0; gi < NO_OF_INS; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign first[gi] = vec[gi];
      end else begin : g_upper
        assign first[gi] = vec[gi] & ~(|vec[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int i = 0; i < NO_OF_INS; i++) begin
      if (first[i]) begin
        idx = idx | i[SELECT-1:0];
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/pending_encoder32.sv
// Latches request pulses into a pending vector and presents the lowest unmasked
// pending index through a valid/ready handshake, clearing the bit on acceptance.
module pending_encoder32
  import pending_enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NO_OF_INS-1:0] req_in,
  input  logic [NO_OF_INS-1:0] mask_in,
  input  logic                 enc_ready_in,
  output logic                 enc_valid_out,
  output logic [SELECT-1:0]    enc_idx_out,
  output logic [NO_OF_INS-1:0] pending_out,
  output logic                 ovf_out
);

  state_t               state_reg, state_next;
  logic [SELECT-1:0]    idx_reg, idx_next;
  logic [NO_OF_INS-1:0] pending_reg, pending_next;
  logic                 ovf_reg, ovf_next;

  logic                 hs;
  logic                 load_idx;
  logic [NO_OF_INS-1:0] clr;
  logic [NO_OF_INS-1:0] cand;
  logic [SELECT-1:0]    cand_idx;
  logic                 cand_any;

  assign hs  = (state_reg == PRESENT) & enc_ready_in;
  assign clr = hs ? onehot(idx_reg) : '0;

  // Set wins over clear: a request on the line being accepted keeps it pending.
  assign pending_next = (pending_reg & ~clr) | req_in;
  assign cand         = pending_next & ~mask_in;
  assign ovf_next     = ovf_reg | (|(req_in & pending_reg & ~clr));

  prio_enc32_5 u_prio (
    .vec (cand),
    .idx (cand_idx),
    .any (cand_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pending_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cand_any) state_next = PRESENT;
      PRESENT: if (hs)       state_next = cand_any ? PRESENT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new index (and the mask) is only sampled when nothing is being held.
  always_comb begin
    load_idx = ((state_reg == IDLE) | hs) & cand_any;
    idx_next = load_idx ? cand_idx : idx_reg;
  end

  assign enc_valid_out = (state_reg == PRESENT);
  assign enc_idx_out   = idx_reg;
  assign pending_out   = pending_reg;
  assign ovf_out       = ovf_reg;

endmodule

// File: tb/tb_pending_encoder32.sv
// Scoreboard bench: a set-based reference model predicts each cycle's outputs,
// a separate monitor compares them against the DUT after every clock edge.
module tb_pending_encoder32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_in = '0;
  logic [31:0] mask_in = '0;
  logic        enc_ready_in = 1'b0;
  logic        enc_valid_out;
  logic [4:0]  enc_idx_out;
  logic [31:0] pending_out;
  logic        ovf_out;

  pending_encoder32 dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .mask_in       (mask_in),
    .enc_ready_in  (enc_ready_in),
    .enc_valid_out (enc_valid_out),
    .enc_idx_out   (enc_idx_out),
    .pending_out   (pending_out),
    .ovf_out       (ovf_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    int        idx;
    bit [31:0] pend;
    bit        ovf;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state
  bit        m_valid = 0;
  int        m_idx   = 0;
  bit [31:0] m_pend  = '0;
  bit        m_ovf   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a full output snapshot after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk("valid",   {31'b0, enc_valid_out}, {31'b0, e.valid});
      chk("idx",     {27'b0, enc_idx_out},   e.idx);
      chk("pending", pending_out,            e.pend);
      chk("ovf",     {31'b0, ovf_out},       {31'b0, e.ovf});
    end
  end

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_pend  = '0;
    m_ovf   = 0;
  endtask

  // Drive one cycle of stimulus and predict the state after the next edge.
  task automatic step(input logic [31:0] req, input logic [31:0] mask, input logic ready);
    bit        hs;
    bit [31:0] np;
    int        found;
    exp_t      e;
    @(negedge clk);
    req_in       = req;
    mask_in      = mask;
    enc_ready_in = ready;
    hs = m_valid && ready;
    np = m_pend;
    if (hs) begin
      np[m_idx] = 1'b0;
      $display("accept idx=%0d", m_idx);
    end
    for (int i = 0; i < 32; i++) begin
      if (req[i]) begin
        if (m_pend[i] && !(hs && m_idx == i)) m_ovf = 1;
        np[i] = 1'b1;
      end
    end
    if (!m_valid || hs) begin
      found = -1;
      for (int i = 31; i >= 0; i--) begin
        if (np[i] && !mask[i]) found = i;
      end
      if (found >= 0) begin
        m_valid = 1;
        m_idx   = found;
      end else begin
        m_valid = 0;
      end
    end
    m_pend  = np;
    e.valid = m_valid;
    e.idx   = m_idx;
    e.pend  = m_pend;
    e.ovf   = m_ovf;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},   {31'b0, enc_valid_out}, 32'd0);
    chk({tag, "_idx"},     {27'b0, enc_idx_out},   32'd0);
    chk({tag, "_pending"}, pending_out,            32'd0);
    chk({tag, "_ovf"},     {31'b0, ovf_out},       32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single request, accepted immediately
    step(32'h0000_0100, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // Priority and hold: a lower new request must not displace index 4
    step(32'h8000_0010, '0, 1'b0);
    step('0, '0, 1'b0);
    step(32'h0000_0002, '0, 1'b0);
    step('0, 32'h0000_0010, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);

    // Masked pending line stays idle until the mask drops
    step(32'h0000_0008, 32'h0000_0008, 1'b0);
    for (int i = 0; i < 10; i++) step('0, 32'h0000_0008, 1'b1);
    step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // Set wins over clear, then a true overflow
    step(32'h0000_0020, '0, 1'b0);
    step(32'h0000_0020, '0, 1'b1);
    step(32'h0000_0020, '0, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // Burst on every line
    step(32'hFFFF_FFFF, '0, 1'b1);
    for (int i = 0; i < 33; i++) step('0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom & $urandom & $urandom,
           $urandom & $urandom,
           1'(($urandom_range(0, 3) != 0)));
    end
    for (int i = 0; i < 40; i++) step('0, '0, 1'b1);

    // Asynchronous reset in the middle of PRESENT with pending lines
    step(32'h0000_00F0, '0, 1'b0);
    step(32'h0000_0010, '0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    req_in       = '0;
    mask_in      = '0;
    enc_ready_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(32'h0000_0100, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pending_encoder32.md
# pending_encoder32

Registered 32-to-5 priority encoder with event latching and a valid/ready output handshake, the inverse of the one-hot select decoder used for register-file write enables. Collects one-hot or multi-hot request pulses into a pending vector and presents the lowest-numbered unmasked pending index, one at a time, to a downstream consumer (trap/interrupt cause logic, writeback arbitration). The pending bit is cleared on acceptance.

## Interface
- NO_OF_INS, 32, number of request lines
- SELECT, $clog2(NO_OF_INS), index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_in  in  NO_OF_INS  request pulses; bit i high in a cycle sets pending[i]
- mask_in  in  NO_OF_INS  1 = line i ineligible for selection (still latched)
- enc_ready_in  in  1  consumer accepts the presented index
- enc_valid_out  out  1  enc_idx_out holds a valid index
- enc_idx_out  out  SELECT  presented index (lowest eligible)
- pending_out  out  NO_OF_INS  current pending vector
- ovf_out  out  1  sticky: a request hit an already-pending line

## Operation
- Two states: IDLE (enc_valid_out=0), PRESENT (enc_valid_out=1).
- Handshake hs = enc_valid_out & enc_ready_in.
- clr = hs ? onehot(enc_idx_out) : 0.
- pending_next = (pending & ~clr) | req_in. Set wins over clear: req_in[idx] in the handshake cycle leaves pending[idx]=1.
- cand = pending_next & ~mask_in. Lowest set bit of cand has priority.
- IDLE: if cand != 0, load enc_idx_out = lowest(cand), go PRESENT. Else stay IDLE.
- PRESENT, no hs: hold enc_idx_out and enc_valid_out stable. Mask changes and new lower-index requests do not retract or change the presented index.
- PRESENT, hs: if cand != 0, load the new lowest(cand) and stay PRESENT (back-to-back). Else go IDLE.
- ovf_out sets when req_in[i] & pending[i] & ~clr[i] for any i. Cleared only by rst.
- enc_idx_out in IDLE retains its last value. Consumers must qualify it with enc_valid_out.
- Width rules: the index is zero-extended into onehot, so indices >= NO_OF_INS never occur. NO_OF_INS must be a power of two.

## Timing
- Reset (async, on rst high, no clock needed): state=IDLE, enc_valid_out=0, enc_idx_out=0, pending_out=0, ovf_out=0. Reset mid-PRESENT drops the presented index and all pending events.
- Latency: req_in high in cycle N gives pending_out and enc_valid_out/enc_idx_out updated at the edge ending cycle N, visible in cycle N+1.
- Throughput: one index per cycle while enc_ready_in is held high and eligible lines remain.
- All outputs are registered. There is no combinational path from inputs to outputs.
- mask_in is sampled only when the next index is selected (in IDLE, or in PRESENT on hs).
- Simultaneous req on all 32 lines: pending=all ones, then indices 0..31 are presented in order over 32 accepted cycles.
- An all-masked pending vector leaves the block in IDLE with pending retained. Selection occurs the cycle after a mask bit drops.

## Structure
- Shared package (e.g. `pending_enc_pkg`): NO_OF_INS, SELECT constants and the state encoding (IDLE=0, PRESENT=1).
- One sub-module, `prio_enc32_5`: combinational lowest-set-bit encoder, NO_OF_INS → SELECT index plus an any-bit flag. Instantiated once on cand.
- Top module holds the pending register, state flop, index register and ovf flop.

## Test plan
- Reset: assert rst mid-PRESENT with pending=32'h0000_00F0 → all outputs 0 immediately, with no clock edge needed.
- Single request: req_in=32'h0000_0100 for one cycle, ready=1 → next cycle valid=1, idx=8. Following cycle valid=0, pending=0.
- Priority and hold: req_in=32'h8000_0010, ready=0 → idx=4 stays stable. Then pulse req_in bit 1 → idx remains 4, pending=32'h8000_0012. Raise ready → idx sequence 4, 1, 31 over consecutive cycles.
- Mask: pending bit 3 with mask_in bit 3 high → valid stays 0 for 10 cycles. Drop mask → valid=1, idx=3 on the next cycle.
- Set-wins and overflow: during hs on idx=5, req_in bit 5=1 → pending[5] stays 1, idx=5 is presented again, ovf_out=0. Then req_in bit 5 with no hs → ovf_out=1, sticky until rst.
- Burst: req_in=32'hFFFF_FFFF, ready=1 → idx 0..31 on 32 consecutive cycles, then valid=0 and pending=0.
